// File: rtl/ysyx_23060025_axi_arbiter.sv
// Read-channel arbiter: merges IFU fetches and LSU loads onto one AXI read port, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN to alternate simultaneous grants; default build gives the LSU fixed priority.
module ysyx_23060025_axi_arbiter #(
    parameter int                  ADDR_LEN   = 32,
    parameter int                  DATA_LEN   = 32,
    parameter logic [ADDR_LEN-1:0] CLINT_BASE = 32'h0200_0000
) (
    input  logic                clock,
    input  logic                rstn,

    input  logic [ADDR_LEN-1:0] ifu_ar_addr_i,
    input  logic                ifu_ar_valid_i,
    output logic                ifu_ar_ready_o,
    output logic [DATA_LEN-1:0] ifu_r_data_o,
    output logic                ifu_r_valid_o,
    input  logic                ifu_r_ready_i,

    input  logic [ADDR_LEN-1:0] lsu_ar_addr_i,
    input  logic [2:0]          lsu_ar_size_i,
    input  logic                lsu_ar_valid_i,
    output logic                lsu_ar_ready_o,
    output logic [DATA_LEN-1:0] lsu_r_data_o,
    output logic                lsu_r_valid_o,
    input  logic                lsu_r_ready_i,

    output logic [ADDR_LEN-1:0] ar_addr_o,
    output logic [2:0]          ar_size_o,
    output logic [7:0]          ar_len_o,
    output logic                ar_valid_o,
    input  logic                ar_ready_i,

    input  logic [DATA_LEN-1:0] r_data_i,
    input  logic                r_valid_i,
    input  logic                r_last_i,
    output logic                r_ready_o,

    output logic                axi_device_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    state_e              state;
    owner_e              owner;
    logic                prefer_ifu;
    logic                ifu_grant;
    logic                lsu_grant;
    logic [ADDR_LEN-1:0] grant_addr;
    logic                in_data;

`ifdef ARB_ROUND_ROBIN_EN
    owner_e last_granted;
    assign prefer_ifu = (last_granted == OWN_LSU);
`else
    assign prefer_ifu = 1'b0;
`endif

    // Grants are decided combinationally in IDLE so the winner's ready lines up with its valid.
    assign ifu_grant  = rstn && (state == IDLE) && ifu_ar_valid_i && (!lsu_ar_valid_i || prefer_ifu);
    assign lsu_grant  = rstn && (state == IDLE) && lsu_ar_valid_i && !(ifu_ar_valid_i && prefer_ifu);
    assign grant_addr = lsu_grant ? lsu_ar_addr_i : ifu_ar_addr_i;

    assign ifu_ar_ready_o = ifu_grant;
    assign lsu_ar_ready_o = lsu_grant;
    assign ar_len_o       = 8'd0;

    assign in_data       = (state == DATA);
    assign r_ready_o     = in_data && ((owner == OWN_LSU) ? lsu_r_ready_i : ifu_r_ready_i);
    assign ifu_r_valid_o = in_data && (owner == OWN_IFU) && r_valid_i;
    assign lsu_r_valid_o = in_data && (owner == OWN_LSU) && r_valid_i;
    assign ifu_r_data_o  = (in_data && (owner == OWN_IFU)) ? r_data_i : '0;
    assign lsu_r_data_o  = (in_data && (owner == OWN_LSU)) ? r_data_i : '0;

    // Transaction FSM; request attributes and target select are latched once at grant.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            owner        <= OWN_IFU;
            ar_addr_o    <= '0;
            ar_size_o    <= 3'b000;
            ar_valid_o   <= 1'b0;
            axi_device_o <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_granted <= OWN_LSU;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (ifu_grant || lsu_grant) begin
                        state        <= ADDR;
                        owner        <= lsu_grant ? OWN_LSU : OWN_IFU;
                        ar_addr_o    <= grant_addr;
                        ar_size_o    <= lsu_grant ? lsu_ar_size_i : 3'b010;
                        ar_valid_o   <= 1'b1;
                        axi_device_o <= (grant_addr[ADDR_LEN-1:16] == CLINT_BASE[ADDR_LEN-1:16]);
`ifdef ARB_ROUND_ROBIN_EN
                        last_granted <= lsu_grant ? OWN_LSU : OWN_IFU;
`endif
                    end
                end
                ADDR: begin
                    if (ar_ready_i) begin
                        state      <= DATA;
                        ar_valid_o <= 1'b0;
                    end
                end
                DATA: begin
                    if (r_valid_i && r_ready_o && r_last_i) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    ar_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
